// File: rtl/shift_register_n.sv
// Multi-mode WIDTH-bit shift register: load, clear, shifts and rotates.
// Multi-bit shifts run serially, one bit per clock, under a start/busy/done handshake.
module shift_register_n #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] amt,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q,
  output logic               co,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_CLEAR = 3'b001;
  localparam logic [2:0] OP_LSL   = 3'b010;
  localparam logic [2:0] OP_LSR   = 3'b011;
  localparam logic [2:0] OP_ASR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   q_r, q_s;
  logic               co_r, co_s;
  logic [SHAMT_W-1:0] cnt_r, cnt_s;
  logic [2:0]         op_r, op_s;

  // One 1-bit step; result is {carry_out, new_value}.
  function automatic logic [WIDTH:0] step(input logic [2:0] sop, input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    case (sop)
      OP_LSL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  // Next-state, datapath and counter decode.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    co_s    = co_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          op_s  = op;
          cnt_s = amt;
          case (op)
            OP_LOAD: begin
              q_s     = d;
              co_s    = 1'b0;
              state_s = ST_DONE;
            end
            OP_CLEAR: begin
              q_s     = {WIDTH{1'b0}};
              co_s    = 1'b0;
              state_s = ST_DONE;
            end
            OP_NOP: begin
              state_s = ST_DONE;
            end
            default: begin
              if (amt == CNT_ZERO) begin
                state_s = ST_DONE;
              end else begin
                state_s = ST_SHIFT;
              end
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        {co_s, q_s} = step(op_r, q_r);
        cnt_s       = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        // Unreachable encoding: recover to a clean idle state.
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, data and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      q_r     <= {WIDTH{1'b0}};
      co_r    <= 1'b0;
      cnt_r   <= CNT_ZERO;
      op_r    <= OP_NOP;
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      co_r    <= co_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
    end
  end

  assign q    = q_r;
  assign co   = co_r;
  assign busy = (state_r != ST_IDLE);
  assign done = (state_r == ST_DONE);

endmodule

// File: tb/tb_shift_register_n.sv
// Directed-vector bench for shift_register_n (WIDTH=8, SHAMT_W=3).
module tb_shift_register_n;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b111;
  logic [2:0] amt = 3'd0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       co, busy, done;

  int vectors = 0;
  int miscompares = 0;

  shift_register_n #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .amt(amt),
    .d(d), .q(q), .co(co), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for done, check latency, result and return to idle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [2:0] a,
                        input logic [7:0] din, input int lat,
                        input logic [7:0] exp_q, input logic exp_co);
    int n;
    start = 1'b1; op = o; amt = a; d = din;
    cyc();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_q"}, q, exp_q);
    check({tag, "_co"}, co, exp_co);
    cyc();
    check({tag, "_idle"}, {busy, done}, 2'b00);
    check({tag, "_hold"}, q, exp_q);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_q", q, 8'h00);
    check("rst_flags", {co, busy, done}, 3'b000);
    #10 reset_n = 1'b1;
    cyc(); cyc();
    check("post_rst_q", q, 8'h00);
    check("post_rst_flags", {co, busy, done}, 3'b000);

    // LOAD then LSL 3, with a per-cycle look at the shift
    run_op("load_a5", 3'b000, 3'd5, 8'hA5, 0, 8'hA5, 1'b0);
    start = 1'b1; op = 3'b010; amt = 3'd3; d = 8'h00;
    cyc();
    start = 1'b0;
    check("lsl_e0", {busy, done, q}, {2'b10, 8'hA5});
    cyc();
    check("lsl_e1", {busy, done, co, q}, {3'b101, 8'h4A});
    cyc();
    check("lsl_e2", {busy, done, co, q}, {3'b100, 8'h94});
    cyc();
    check("lsl_e3", {busy, done, co, q}, {3'b111, 8'h28});
    cyc();
    check("lsl_e4", {busy, done, co, q}, {3'b001, 8'h28});

    run_op("load_90a", 3'b000, 3'd0, 8'h90, 0, 8'h90, 1'b0);
    run_op("asr2", 3'b100, 3'd2, 8'h00, 2, 8'hE4, 1'b0);
    run_op("load_90b", 3'b000, 3'd0, 8'h90, 0, 8'h90, 1'b0);
    run_op("lsr2", 3'b011, 3'd2, 8'h00, 2, 8'h24, 1'b0);
    run_op("load_81a", 3'b000, 3'd0, 8'h81, 0, 8'h81, 1'b0);
    run_op("ror1", 3'b110, 3'd1, 8'h00, 1, 8'hC0, 1'b1);
    run_op("load_81b", 3'b000, 3'd0, 8'h81, 0, 8'h81, 1'b0);
    run_op("rol7", 3'b101, 3'd7, 8'h00, 7, 8'hC0, 1'b0);
    run_op("load_ff", 3'b000, 3'd0, 8'hFF, 0, 8'hFF, 1'b0);
    run_op("lsl7", 3'b010, 3'd7, 8'h00, 7, 8'h80, 1'b1);
    run_op("load_80", 3'b000, 3'd0, 8'h80, 0, 8'h80, 1'b0);
    run_op("asr7", 3'b100, 3'd7, 8'h00, 7, 8'hFF, 1'b0);

    // Handshake: start held high, inputs churned while busy
    run_op("load_0f", 3'b000, 3'd0, 8'h0F, 0, 8'h0F, 1'b0);
    start = 1'b1; op = 3'b101; amt = 3'd5; d = 8'h00;
    cyc();
    for (int i = 1; i <= 5; i++) begin
      op = 3'(i); amt = 3'(7 - i); d = 8'h55 + 8'(i);
      cyc();
      check("hs_busy", busy, 1'b1);
      check("hs_done", done, (i == 5) ? 1'b1 : 1'b0);
    end
    start = 1'b0;
    check("hs_q", {co, q}, {1'b1, 8'hE1});
    cyc();
    check("hs_end", {busy, done, co, q}, {3'b001, 8'hE1});

    run_op("ror0", 3'b110, 3'd0, 8'h00, 0, 8'hE1, 1'b1);
    run_op("nop", 3'b111, 3'd4, 8'h12, 0, 8'hE1, 1'b1);
    run_op("clear", 3'b001, 3'd0, 8'h34, 0, 8'h00, 1'b0);

    // Reset in the middle of a shift
    run_op("load_ff2", 3'b000, 3'd0, 8'hFF, 0, 8'hFF, 1'b0);
    start = 1'b1; op = 3'b011; amt = 3'd7; d = 8'h00;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    check("mid_q", {busy, done, q}, {2'b10, 8'h1F});
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst", {busy, done, co, q}, {3'b000, 8'h00});
    #3 reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      check("mid_no_done", {busy, done, q}, {2'b00, 8'h00});
    end
    run_op("load_3c", 3'b000, 3'd0, 8'h3C, 0, 8'h3C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
